// File: rtl/pll_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pll_seq_pkg                                                  |
// | Description : Shared types and elaboration helpers for the PLL reset       |
// |               sequencer (state encoding, counter width helpers).           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pll_seq_pkg;

  // Sequencer states; explicit 3-bit encoding leaves 5..7 as invalid codes.
  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  // Ceiling log2, never returning less than 1 so it is always a legal width.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

  // Largest of three cycle-count parameters, used to size the shared counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage : pll_seq_pkg
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bit_sync                                                     |
// | Description : Two-flop synchronizer for a single asynchronous level, with  |
// |               asynchronous active-high reset to 0.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bit_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  // Next values: stage 1 captures the raw input, stage 2 resolves stage 1.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops, cleared asynchronously so reset never needs a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule : bit_sync
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pll_reset_sequencer                                          |
// | Description : Holds the clock-bridge PLL in reset, waits for a stable      |
// |               lock, then releases system reset. Retries on lock timeout or |
// |               lock loss and latches a sticky failure after repeated        |
// |               timeouts.                                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int HOLD_CYCLES    = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES    = 3,
  parameter int LOSS_W         = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pll_locked,
  input  logic                             clear_fail,
  output logic                             pll_reset,
  output logic                             sys_reset,
  output logic                             lock_ok,
  output logic                             fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count,
  output logic [LOSS_W-1:0]                loss_count
);

  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int CW = clog2(max3(HOLD_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES) + 1);

  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

  logic locked_s;

  state_t            state_q,     state_d;
  logic [CW-1:0]     cnt_q,       cnt_d;
  logic [RW-1:0]     retry_q,     retry_d;
  logic [LOSS_W-1:0] loss_q,      loss_d;
  logic              pll_reset_q, pll_reset_d;
  logic              sys_reset_q, sys_reset_d;
  logic              lock_ok_q,   lock_ok_d;
  logic              fail_q,      fail_d;

  // The PLL lock indication is asynchronous; only the synchronized copy is used.
  bit_sync u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // Next-state, counter and status computation; outputs decode the next state
  // so they change on the same edge as the state register.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    case (state_q)
      RESET_PLL: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        // Lock seen on the final cycle wins over the timeout.
        if (locked_s) begin
          state_d = STABILIZE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q == RETRY_LIMIT) begin
            state_d = FAIL;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = RESET_PLL;
          end
        end
      end
      STABILIZE: begin
        // A drop at any point, including the last cycle, restarts the wait.
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          retry_d = '0;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = RESET_PLL;
          if (loss_q != {LOSS_W{1'b1}}) begin
            loss_d = loss_q + LOSS_W'(1);
          end
        end
      end
      FAIL: begin
        if (clear_fail) begin
          state_d = RESET_PLL;
          retry_d = '0;
        end
      end
      default: begin
        state_d = RESET_PLL;
      end
    endcase

    // Shared timer: restarts on every state change, frozen while failed.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == FAIL) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    pll_reset_d = (state_d == RESET_PLL) || (state_d == FAIL);
    sys_reset_d = (state_d != RUN);
    lock_ok_d   = (state_d == RUN);
    fail_d      = (state_d == FAIL);
  end

  // State, timer and registered outputs; reset asserts both resets without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      lock_ok_q   <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_reset_q <= pll_reset_d;
      sys_reset_q <= sys_reset_d;
      lock_ok_q   <= lock_ok_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_reset   = pll_reset_q;
  assign sys_reset   = sys_reset_q;
  assign lock_ok     = lock_ok_q;
  assign fail        = fail_q;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;

endmodule : pll_reset_sequencer
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pll_reset_sequencer                                       |
// | Description : Self-checking bench for pll_reset_sequencer with a          |
// |               phase/timestamp reference model.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pll_reset_sequencer;

  localparam int HOLD    = 4;
  localparam int STABLE  = 8;
  localparam int TIMEOUT = 32;
  localparam int MAXR    = 2;
  localparam int LOSS_W  = 8;
  localparam int RW      = 2;
  localparam int LOSS_MAX = (1 << LOSS_W) - 1;

  localparam int PH_HOLD = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_STAB = 2;
  localparam int PH_RUN  = 3;
  localparam int PH_FAIL = 4;

  localparam logic [13:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pll_locked = 1'b0;
  logic clear_fail = 1'b0;
  logic pll_reset, sys_reset, lock_ok, fail;
  logic [RW-1:0] retry_count;
  logic [LOSS_W-1:0] loss_count;
  logic [13:0] obs;

  assign obs = {pll_reset, sys_reset, lock_ok, fail, retry_count, loss_count};

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .HOLD_CYCLES    (HOLD),
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TIMEOUT),
    .MAX_RETRIES    (MAXR),
    .LOSS_W         (LOSS_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .clear_fail  (clear_fail),
    .pll_reset   (pll_reset),
    .sys_reset   (sys_reset),
    .lock_ok     (lock_ok),
    .fail        (fail),
    .retry_count (retry_count),
    .loss_count  (loss_count)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: phase, edge count at which the phase was entered, counts.
  int cyc = 0;
  int m_ph = PH_HOLD;
  int m_enter = 0;
  int m_retries = 0;
  int m_losses = 0;
  bit m_s1 = 1'b0;
  bit m_s2 = 1'b0;
  bit m_in = 1'b0;

  function automatic void model_reset();
    m_ph = PH_HOLD;
    m_enter = cyc;
    m_retries = 0;
    m_losses = 0;
    m_s1 = 1'b0;
    m_s2 = 1'b0;
  endfunction

  function automatic void model_step(input bit li, input bit cf);
    int t;
    int nxt;
    bit ls;
    t = cyc - 1 - m_enter;
    ls = m_s2;
    m_s2 = m_s1;
    m_s1 = li;
    nxt = m_ph;
    if (m_ph == PH_HOLD) begin
      if (t == HOLD - 1) nxt = PH_WAIT;
    end else if (m_ph == PH_WAIT) begin
      if (ls) nxt = PH_STAB;
      else if (t == TIMEOUT - 1) begin
        if (m_retries == MAXR) nxt = PH_FAIL;
        else begin
          m_retries = m_retries + 1;
          nxt = PH_HOLD;
        end
      end
    end else if (m_ph == PH_STAB) begin
      if (!ls) nxt = PH_WAIT;
      else if (t == STABLE - 1) begin
        nxt = PH_RUN;
        m_retries = 0;
      end
    end else if (m_ph == PH_RUN) begin
      if (!ls) begin
        nxt = PH_HOLD;
        if (m_losses < LOSS_MAX) m_losses = m_losses + 1;
      end
    end else if (m_ph == PH_FAIL) begin
      if (cf) begin
        nxt = PH_HOLD;
        m_retries = 0;
      end
    end
    if (nxt != m_ph) begin
      m_ph = nxt;
      m_enter = cyc;
    end
  endfunction

  function automatic logic [13:0] exp_vec();
    logic [13:0] v;
    v = {(m_ph == PH_HOLD) || (m_ph == PH_FAIL), m_ph != PH_RUN, m_ph == PH_RUN,
         m_ph == PH_FAIL, RW'(m_retries), LOSS_W'(m_losses)};
    return v;
  endfunction

  // One clock edge: sample inputs at the edge, advance the model, settle 1ns.
  task automatic tick();
    bit cf;
    @(posedge clk);
    m_in = pll_locked;
    cf = clear_fail;
    cyc = cyc + 1;
    if (reset) model_reset();
    else model_step(m_in, cf);
    #1;
  endtask

  task automatic test_reset();
    int first_seen;
    int fall;
    reset = 1'b1;
    pll_locked = 1'b0;
    clear_fail = 1'b0;
    repeat (3) tick();
    n_chk++;
    if (obs !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_values got=%b exp=%b", obs, RESET_VEC);
    end
    reset = 1'b0;
    first_seen = -1;
    fall = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (i == 10) pll_locked = 1'b1;
      if (m_in && first_seen < 0) first_seen = cyc;
      if (!sys_reset && fall < 0) fall = cyc;
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL startup_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
      end
      if (i == 3) begin
        n_chk++;
        if (pll_reset !== 1'b1) begin
          n_fail++;
          $display("FAIL hold_high got=%b exp=1", pll_reset);
        end
      end
      if (i == 4) begin
        n_chk++;
        if (pll_reset !== 1'b0) begin
          n_fail++;
          $display("FAIL hold_release got=%b exp=0", pll_reset);
        end
      end
    end
    n_chk++;
    if (fall < 0 || first_seen < 0 || (fall - first_seen) != STABLE + 2) begin
      n_fail++;
      $display("FAIL lock_latency got=%0d exp=%0d", fall - first_seen, STABLE + 2);
    end
    n_chk++;
    if (lock_ok !== 1'b1 || retry_count !== 2'd0) begin
      n_fail++;
      $display("FAIL run_entry lock_ok=%b retry=%0d exp lock_ok=1 retry=0", lock_ok, retry_count);
    end
  endtask

  task automatic test_loss();
    int drop;
    int hold_cnt;
    bit done;
    repeat ($urandom_range(0, 5)) tick();
    pll_locked = 1'b0;
    tick();
    drop = cyc;
    pll_locked = 1'b1;
    hold_cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      tick();
      if (pll_reset) hold_cnt++;
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL loss_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
      end
      if (cyc == drop + 2) begin
        n_chk++;
        if (sys_reset !== 1'b1 || loss_count !== 8'd1) begin
          n_fail++;
          $display("FAIL loss_react sys_reset=%b loss=%0d exp 1/1", sys_reset, loss_count);
        end
      end
      if (i > 3 && lock_ok) done = 1'b1;
    end
    n_chk++;
    if (!done || hold_cnt != HOLD) begin
      n_fail++;
      $display("FAIL loss_recover done=%b hold_cycles=%0d exp done=1 hold=%0d", done, hold_cnt, HOLD);
    end
  endtask

  task automatic test_glitch();
    int restore;
    int fall;
    int retries_before;
    bit hit;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL glitch_pre cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
      end
      if (m_ph == PH_STAB && (cyc - m_enter) == 5) hit = 1'b1;
    end
    retries_before = m_retries;
    pll_locked = 1'b0;
    repeat (2) tick();
    pll_locked = 1'b1;
    restore = cyc + 1;
    fall = -1;
    for (int i = 0; i < 60 && fall < 0; i++) begin
      tick();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL glitch_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
      end
      if (!sys_reset) fall = cyc;
    end
    n_chk++;
    if (!hit || fall - restore != STABLE + 2) begin
      n_fail++;
      $display("FAIL glitch_restart latency=%0d exp=%0d", fall - restore, STABLE + 2);
    end
    n_chk++;
    if (retry_count !== RW'(retries_before)) begin
      n_fail++;
      $display("FAIL glitch_retry got=%0d exp=%0d", retry_count, retries_before);
    end
  endtask

  task automatic test_timeout();
    int start;
    int t_fail;
    bit done;
    pll_locked = 1'b0;
    start = -1;
    t_fail = -1;
    for (int i = 0; i < 300 && t_fail < 0; i++) begin
      tick();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL timeout_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
      end
      if (start < 0 && pll_reset) start = cyc;
      if (start >= 0 && cyc == start + HOLD + TIMEOUT) begin
        n_chk++;
        if (retry_count !== 2'd1) begin
          n_fail++;
          $display("FAIL retry_one got=%0d exp=1", retry_count);
        end
      end
      if (fail) t_fail = cyc;
      else clear_fail = ($urandom_range(0, 7) == 0);
    end
    clear_fail = 1'b0;
    n_chk++;
    if (t_fail - start != 3 * (HOLD + TIMEOUT) || pll_reset !== 1'b1 || retry_count !== 2'd2) begin
      n_fail++;
      $display("FAIL fail_entry edges=%0d exp=%0d pll_reset=%b retry=%0d", t_fail - start,
               3 * (HOLD + TIMEOUT), pll_reset, retry_count);
    end
    repeat ($urandom_range(3, 10)) begin
      tick();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL fail_hold cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
      end
    end
    clear_fail = 1'b1;
    tick();
    clear_fail = 1'b0;
    pll_locked = 1'b1;
    n_chk++;
    if (fail !== 1'b0 || retry_count !== 2'd0) begin
      n_fail++;
      $display("FAIL clear_fail fail=%b retry=%0d exp 0/0", fail, retry_count);
    end
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL clear_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
      end
      if (lock_ok) done = 1'b1;
    end
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL clear_to_run lock_ok=%b exp=1", lock_ok);
    end
  endtask

  task automatic test_saturation();
    bit done;
    for (int n = 0; n < 256; n++) begin
      pll_locked = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
      pll_locked = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
        tick();
        n_chk++;
        if (obs !== exp_vec()) begin
          n_fail++;
          $display("FAIL sat_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
        end
        if (i > 3 && lock_ok) done = 1'b1;
      end
      if (!done) begin
        n_chk++;
        n_fail++;
        $display("FAIL sat_relock iteration=%0d lock_ok=%b exp=1", n, lock_ok);
      end
    end
    n_chk++;
    if (loss_count !== 8'd255) begin
      n_fail++;
      $display("FAIL loss_saturate got=%0d exp=255", loss_count);
    end
  endtask

  task automatic test_async_reset();
    bit hit;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick();
      if (m_ph == PH_STAB && (cyc - m_enter) == 3) hit = 1'b1;
    end
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_chk++;
    if (!hit || obs !== RESET_VEC) begin
      n_fail++;
      $display("FAIL async_reset_stab got=%b exp=%b", obs, RESET_VEC);
    end
    tick();
    reset = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      tick();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL async_relock cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
      end
      if (lock_ok) hit = 1'b1;
    end
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    n_chk++;
    if (!hit || obs !== RESET_VEC) begin
      n_fail++;
      $display("FAIL async_reset_run got=%b exp=%b", obs, RESET_VEC);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) pll_locked = ~pll_locked;
      clear_fail = ($urandom_range(0, 9) == 0);
      tick();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
      end
    end
    clear_fail = 1'b0;
  endtask

  initial begin
    test_reset();
    test_loss();
    test_glitch();
    test_timeout();
    test_saturation();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_pll_reset_sequencer
`default_nettype wire
